// File: rtl/z80fi_pkg.sv
// z80fi_pkg: shared types and widths for the z80fi formal-interface blocks
package z80fi_pkg;
  typedef enum logic {IDLE, COLLECT} collector_state_t;
  localparam int Z80FI_MAX_INSN_LEN = 4;
  localparam int Z80FI_LEN_W = 3;
endpackage

// File: rtl/z80fi_insn_collector.sv
// z80fi_insn_collector: assembles fetched bytes of each retiring instruction into z80fi fields
module z80fi_insn_collector
  import z80fi_pkg::*;
#(
  parameter int MAX_LEN = Z80FI_MAX_INSN_LEN
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   fetch_valid,
  input  logic                   fetch_first,
  input  logic [15:0]            fetch_addr,
  input  logic [7:0]             fetch_data,
  input  logic                   insn_retire,
  output logic                   z80fi_valid,
  output logic [8*MAX_LEN-1:0]   z80fi_insn,
  output logic [Z80FI_LEN_W-1:0] z80fi_insn_len,
  output logic [15:0]            z80fi_pc_rdata,
  output logic                   z80fi_error
);
  collector_state_t state;
  logic [8*MAX_LEN-1:0] acc, acc_n;
  logic [Z80FI_LEN_W-1:0] cnt, cnt_n;
  logic [15:0] pc, pc_n;
  logic idle, fresh, append, overflow, keep_old, publish, clear, err_set;
  assign idle     = state == IDLE;
  assign fresh    = fetch_valid & fetch_first;
  assign append   = fetch_valid & !fetch_first & !idle & (cnt != Z80FI_LEN_W'(MAX_LEN));
  assign overflow = fetch_valid & !fetch_first & !idle & (cnt == Z80FI_LEN_W'(MAX_LEN));
  // A first-byte fetch while collecting publishes (on retire) the old insn, not the new byte
  assign keep_old = fresh & !idle;
  assign publish  = insn_retire & (!idle | fresh);
  assign clear    = publish & !keep_old;
  assign err_set  = (idle & fetch_valid & !fetch_first) | (idle & insn_retire & !fetch_valid) |
                    overflow | (keep_old & !insn_retire);
  assign cnt_n    = fresh ? Z80FI_LEN_W'(1) : cnt + {{(Z80FI_LEN_W-1){1'b0}}, append};
  assign pc_n     = fresh ? fetch_addr : pc;
  genvar k;
  for (k = 0; k < MAX_LEN; k++) begin : g_lane
    assign acc_n[8*k+:8] = ((fresh && k == 0) || (append && cnt == Z80FI_LEN_W'(k))) ? fetch_data :
                           fresh ? 8'h00 : acc[8*k+:8];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      acc            <= '0;
      cnt            <= '0;
      pc             <= '0;
      z80fi_valid    <= 1'b0;
      z80fi_insn     <= '0;
      z80fi_insn_len <= '0;
      z80fi_pc_rdata <= '0;
      z80fi_error    <= 1'b0;
    end else begin
      state       <= clear ? IDLE : fresh ? COLLECT : state;
      acc         <= clear ? '0 : acc_n;
      cnt         <= clear ? '0 : cnt_n;
      pc          <= clear ? '0 : pc_n;
      z80fi_error <= z80fi_error | err_set;
      z80fi_valid <= publish;
      if (publish) begin
        z80fi_insn     <= keep_old ? acc : acc_n;
        z80fi_insn_len <= keep_old ? cnt : cnt_n;
        z80fi_pc_rdata <= keep_old ? pc : pc_n;
      end
    end
  end
endmodule

// File: tb/tb_z80fi_insn_collector.sv
// tb_z80fi_insn_collector: directed checks of byte collection, publish timing and error flagging
module tb_z80fi_insn_collector;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic fetch_valid = 1'b0, fetch_first = 1'b0, insn_retire = 1'b0;
  logic [15:0] fetch_addr = '0;
  logic [7:0] fetch_data = '0;
  logic z80fi_valid, z80fi_error;
  logic [31:0] z80fi_insn;
  logic [2:0] z80fi_insn_len;
  logic [15:0] z80fi_pc_rdata;
  int errors = 0, checks = 0;

  z80fi_insn_collector dut (
    .clk(clk), .reset_n(reset_n), .fetch_valid(fetch_valid), .fetch_first(fetch_first),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .insn_retire(insn_retire),
    .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
    .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_error(z80fi_error)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic fv, input logic ff, input logic [15:0] a, input logic [7:0] d,
                       input logic rt);
    @(negedge clk);
    fetch_valid = fv; fetch_first = ff; fetch_addr = a; fetch_data = d; insn_retire = rt;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    fetch_valid = 0; fetch_first = 0; insn_retire = 0;
    reset_n = 0;
    #2 reset_n = 1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%h exp=0", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL reset_insn got=%h exp=0", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL reset_len got=%h exp=0", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0) begin errors++; $display("FAIL reset_pc got=%h exp=0", z80fi_pc_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL reset_error got=%h exp=0", z80fi_error); end
    @(negedge clk);
    reset_n = 1;
  endtask

  task automatic test_ld_b_n();
    drive(1, 1, 16'h0100, 8'h06, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL ldb_early_valid got=%h exp=0", z80fi_valid); end
    drive(1, 0, 16'h0101, 8'h42, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ldb_valid got=%h exp=1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h00004206) begin errors++; $display("FAIL ldb_insn got=%h exp=00004206", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd2) begin errors++; $display("FAIL ldb_len got=%h exp=2", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0100) begin errors++; $display("FAIL ldb_pc got=%h exp=0100", z80fi_pc_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL ldb_error got=%h exp=0", z80fi_error); end
    drive(0, 0, 16'h0, 8'h0, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL ldb_pulse got=%h exp=0", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h00004206) begin errors++; $display("FAIL ldb_hold got=%h exp=00004206", z80fi_insn); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 16'(i), 8'h00, 1);
      checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL nop%0d_valid got=%h exp=1", i, z80fi_valid); end
      checks++; if (z80fi_insn_len !== 3'd1) begin errors++; $display("FAIL nop%0d_len got=%h exp=1", i, z80fi_insn_len); end
      checks++; if (z80fi_pc_rdata !== 16'(i)) begin errors++; $display("FAIL nop%0d_pc got=%h exp=%h", i, z80fi_pc_rdata, 16'(i)); end
      checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL nop%0d_insn got=%h exp=0", i, z80fi_insn); end
      checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL nop%0d_error got=%h exp=0", i, z80fi_error); end
    end
    drive(0, 0, 16'h0, 8'h0, 0);
  endtask

  task automatic test_ld_ix();
    drive(1, 1, 16'hFFFE, 8'hDD, 0);
    drive(1, 0, 16'hFFFF, 8'h21, 0);
    drive(1, 0, 16'h0000, 8'h34, 0);
    drive(1, 0, 16'h0001, 8'h12, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ldix_valid got=%h exp=1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h123421DD) begin errors++; $display("FAIL ldix_insn got=%h exp=123421dd", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd4) begin errors++; $display("FAIL ldix_len got=%h exp=4", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'hFFFE) begin errors++; $display("FAIL ldix_pc got=%h exp=fffe", z80fi_pc_rdata); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL ldix_error got=%h exp=0", z80fi_error); end
  endtask

  task automatic test_mid_reset();
    drive(1, 1, 16'h0500, 8'h11, 0);
    drive(1, 0, 16'h0501, 8'h22, 0);
    @(negedge clk);
    fetch_valid = 0; fetch_first = 0; insn_retire = 0;
    reset_n = 0;
    #1;
    checks++; if (z80fi_insn !== 32'h0) begin errors++; $display("FAIL midrst_insn got=%h exp=0", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd0) begin errors++; $display("FAIL midrst_len got=%h exp=0", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0) begin errors++; $display("FAIL midrst_pc got=%h exp=0", z80fi_pc_rdata); end
    #1 reset_n = 1;
    drive(0, 0, 16'h0, 8'h0, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%h exp=0", z80fi_valid); end
    drive(1, 1, 16'h0600, 8'h3C, 1);
    checks++; if (z80fi_insn !== 32'h0000003C) begin errors++; $display("FAIL midrst_next got=%h exp=0000003c", z80fi_insn); end
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL midrst_error got=%h exp=0", z80fi_error); end
  endtask

  task automatic test_overflow();
    pulse_reset();
    drive(1, 1, 16'h0200, 8'hA0, 0);
    drive(1, 0, 16'h0201, 8'hA1, 0);
    drive(1, 0, 16'h0202, 8'hA2, 0);
    drive(1, 0, 16'h0203, 8'hA3, 0);
    checks++; if (z80fi_error !== 1'b0) begin errors++; $display("FAIL ovf_early_error got=%h exp=0", z80fi_error); end
    drive(1, 0, 16'h0204, 8'hA4, 0);
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL ovf_error got=%h exp=1", z80fi_error); end
    drive(0, 0, 16'h0, 8'h0, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%h exp=1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'hA3A2A1A0) begin errors++; $display("FAIL ovf_insn got=%h exp=a3a2a1a0", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd4) begin errors++; $display("FAIL ovf_len got=%h exp=4", z80fi_insn_len); end
  endtask

  task automatic test_protocol_error();
    pulse_reset();
    drive(1, 1, 16'h0200, 8'hDD, 0);
    drive(1, 1, 16'h0300, 8'h3E, 0);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL proto_abandon_valid got=%h exp=0", z80fi_valid); end
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL proto_error got=%h exp=1", z80fi_error); end
    drive(1, 0, 16'h0301, 8'h55, 1);
    checks++; if (z80fi_valid !== 1'b1) begin errors++; $display("FAIL proto_valid got=%h exp=1", z80fi_valid); end
    checks++; if (z80fi_insn !== 32'h0000553E) begin errors++; $display("FAIL proto_insn got=%h exp=0000553e", z80fi_insn); end
    checks++; if (z80fi_insn_len !== 3'd2) begin errors++; $display("FAIL proto_len got=%h exp=2", z80fi_insn_len); end
    checks++; if (z80fi_pc_rdata !== 16'h0300) begin errors++; $display("FAIL proto_pc got=%h exp=0300", z80fi_pc_rdata); end
    pulse_reset();
    drive(0, 0, 16'h0, 8'h0, 1);
    checks++; if (z80fi_valid !== 1'b0) begin errors++; $display("FAIL idle_retire_valid got=%h exp=0", z80fi_valid); end
    checks++; if (z80fi_error !== 1'b1) begin errors++; $display("FAIL idle_retire_error got=%h exp=1", z80fi_error); end
  endtask

  initial begin
    test_reset();
    test_ld_b_n();
    test_back_to_back();
    test_ld_ix();
    test_mid_reset();
    test_overflow();
    test_protocol_error();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
